// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request/ack
// handshake with wrong-path squashing, one-word hold buffer, IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pc_srcD,
  input  logic [31:0] pc_branchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pc_plus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic        consume;
  logic [31:0] consume_instr;
  logic [31:0] consume_pc4;
  logic [31:0] addr_plus4;

  assign redirect   = pc_srcD & ~stallD;
  assign addr_plus4 = addr_q + 32'd4;

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = addr_q;
  assign instrD    = instr_q;
  assign pc_plus4D = pc4_q;
  assign validD    = valid_q;

  // Next-state, PC/address tracking, hold buffer and word-consume selection
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    hold_v_d      = hold_v_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    consume       = 1'b0;
    consume_instr = '0;
    consume_pc4   = '0;
    unique case (state_q)
      S_IDLE: begin
        addr_d  = pc_q;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d   = pc_branchD;
            addr_d = pc_branchD;
          end else if (!stallF && !stallD) begin
            consume       = 1'b1;
            consume_instr = imem_rdata;
            consume_pc4   = addr_plus4;
            pc_d          = addr_plus4;
            addr_d        = addr_plus4;
          end else begin
            hold_v_d     = 1'b1;
            hold_instr_d = imem_rdata;
            hold_pc4_d   = addr_plus4;
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          // old request still owes an ack; remember only the new target
          pc_d    = pc_branchD;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = pc_branchD;
        end
        if (imem_ack) begin
          addr_d  = redirect ? pc_branchD : pc_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          hold_v_d = 1'b0;
          pc_d     = pc_branchD;
          addr_d   = pc_branchD;
          state_d  = S_REQ;
        end else if (!stallF && !stallD) begin
          consume       = 1'b1;
          consume_instr = hold_instr_q;
          consume_pc4   = hold_pc4_q;
          hold_v_d      = 1'b0;
          pc_d          = hold_pc4_q;
          addr_d        = hold_pc4_q;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID register next value: hold, bubble, or load consumed word
  always_comb begin
    instr_d = '0;
    pc4_d   = '0;
    valid_d = 1'b0;
    if (stallD) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (consume) begin
      instr_d = consume_instr;
      pc4_d   = consume_pc4;
      valid_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      hold_v_q     <= 1'b0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      hold_v_q     <= hold_v_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, streaming, stall hold,
// wrong-path squash, same-cycle redirect, stallF-only, PC wrap, reset in DROP.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        stallD;
  logic        pc_srcD;
  logic [31:0] pc_branchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instrD;
  logic [31:0] pc_plus4D;
  logic        validD;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stallF     (stallF),
    .stallD     (stallD),
    .pc_srcD    (pc_srcD),
    .pc_branchD (pc_branchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instrD     (instrD),
    .pc_plus4D  (pc_plus4D),
    .validD     (validD)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc4, input logic v);
    check({tag, ".instrD"}, instrD, ins);
    check({tag, ".pc4"}, pc_plus4D, pc4);
    check({tag, ".valid"}, {31'd0, validD}, {31'd0, v});
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, ".req"}, {31'd0, imem_req}, {31'd0, r});
    if (r) check({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; pc_srcD = 1'b0;
    pc_branchD = '0; imem_ack = 1'b0; imem_rdata = '0;

    // T1 reset two cycles, one IDLE cycle, then request at RESET_PC
    tick();
    check_req("t1_rst0", 1'b0, '0);
    tick();
    check_req("t1_rst1", 1'b0, '0);
    check_ifid("t1_rst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    #1;
    check_req("t1_idle", 1'b0, '0);
    tick();
    check_req("t1_req", 1'b1, 32'h0040_0000);

    // T2 zero-wait streaming
    imem_ack = 1'b1; imem_rdata = 32'h2008_0001;
    tick();
    check_ifid("t2_w0", 32'h2008_0001, 32'h0040_0004, 1'b1);
    check_req("t2_a1", 1'b1, 32'h0040_0004);
    imem_rdata = 32'h2009_0002;
    tick();
    check_ifid("t2_w1", 32'h2009_0002, 32'h0040_0008, 1'b1);
    check_req("t2_a2", 1'b1, 32'h0040_0008);

    // T3 word returns while fully stalled: hold it for 3 cycles
    imem_rdata = 32'h200A_0003; stallF = 1'b1; stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_ack = 1'b0;
      check_req("t3_hold", 1'b0, '0);
      check_ifid("t3_ifid", 32'h2009_0002, 32'h0040_0008, 1'b1);
    end
    stallF = 1'b0; stallD = 1'b0;
    tick();
    check_ifid("t3_rel", 32'h200A_0003, 32'h0040_000C, 1'b1);
    check_req("t3_next", 1'b1, 32'h0040_000C);

    imem_ack = 1'b1; imem_rdata = 32'h200B_0004;
    tick();
    check_ifid("t3b", 32'h200B_0004, 32'h0040_0010, 1'b1);
    check_req("t3b_next", 1'b1, 32'h0040_0010);

    // T4 redirect while request pending; stale ack two cycles later
    imem_ack = 1'b0; pc_srcD = 1'b1; pc_branchD = 32'h0040_0100;
    tick();
    pc_srcD = 1'b0;
    check_ifid("t4_c0", 32'h0, 32'h0, 1'b0);
    check_req("t4_old0", 1'b1, 32'h0040_0010);
    tick();
    check_ifid("t4_c1", 32'h0, 32'h0, 1'b0);
    check_req("t4_old1", 1'b1, 32'h0040_0010);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_ifid("t4_c2", 32'h0, 32'h0, 1'b0);
    check_req("t4_new", 1'b1, 32'h0040_0100);
    tick();
    check_ifid("t4_c3", 32'h0, 32'h0, 1'b0);

    // T5 ack and redirect in the same cycle
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    pc_srcD = 1'b1; pc_branchD = 32'h0040_0200;
    tick();
    imem_ack = 1'b0; pc_srcD = 1'b0;
    check_ifid("t5", 32'h0, 32'h0, 1'b0);
    check_req("t5_req", 1'b1, 32'h0040_0200);

    // redirect under stallD is ignored
    pc_srcD = 1'b1; pc_branchD = 32'h0050_0000; stallF = 1'b1; stallD = 1'b1;
    tick();
    pc_srcD = 1'b0; stallF = 1'b0; stallD = 1'b0;
    check_req("sd_ign", 1'b1, 32'h0040_0200);

    // stallF only: IF/ID bubbles, word kept and delivered afterwards
    stallF = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    check_ifid("sf_bub", 32'h0, 32'h0, 1'b0);
    check_req("sf_hold", 1'b0, '0);
    stallF = 1'b0;
    tick();
    check_ifid("sf_rel", 32'h2222_2222, 32'h0040_0204, 1'b1);
    check_req("sf_next", 1'b1, 32'h0040_0204);

    // PC wrap: 0xFFFFFFFC + 4 = 0
    pc_srcD = 1'b1; pc_branchD = 32'hFFFF_FFFC;
    tick();
    pc_srcD = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    check_req("wr_req", 1'b1, 32'hFFFF_FFFC);
    imem_rdata = 32'h3333_3333;
    tick();
    imem_ack = 1'b0;
    check_ifid("wr", 32'h3333_3333, 32'h0, 1'b1);
    check_req("wr_next", 1'b1, 32'h0);

    // T6 reset while in DROP; stale ack during reset and IDLE ignored
    pc_srcD = 1'b1; pc_branchD = 32'h0040_0300;
    tick();
    pc_srcD = 1'b0; rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    check_req("t6_rst", 1'b0, '0);
    check_ifid("t6_rst", 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    imem_ack = 1'b0;
    check_req("t6_req", 1'b1, 32'h0040_0000);
    check_ifid("t6_idle", 32'h0, 32'h0, 1'b0);
    tick();
    check_req("t6_stay", 1'b1, 32'h0040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
